fetch_buffer: RTL and testbench

//   Instruction queue directly downstream of the ICache fetch stage. Accepts up to FETCH_WIDTH

---
 rtl/fetch_buffer_if.sv | 32 +++
 rtl/fetch_buffer.sv | 101 ++++++++++
 tb/tb_fetch_buffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode bus: ICache response group in, oldest decode group out.
// The slave side is the fetch buffer; the master side is the fetch/decode environment.
interface fetch_buffer_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int VALEN        = 32
);
  logic [FETCH_WIDTH-1:0]                  in_valid;
  logic [FETCH_WIDTH-1:0][VALEN-1:0]       in_vaddr;
  logic [FETCH_WIDTH-1:0][31:0]            in_instr;
  logic [FETCH_WIDTH-1:0][VALEN-1:0]       in_npc;
  logic                                    in_excp_valid;
  logic [5:0]                              in_excp_ecode;
  logic                                    in_ready;

  logic [DECODE_WIDTH-1:0]                 out_valid;
  logic [DECODE_WIDTH-1:0][VALEN-1:0]      out_vaddr;
  logic [DECODE_WIDTH-1:0][31:0]           out_instr;
  logic [DECODE_WIDTH-1:0][VALEN-1:0]      out_npc;
  logic [DECODE_WIDTH-1:0][6:0]            out_excp;
  logic                                    out_ready;

  modport master (
    output in_valid, in_vaddr, in_instr, in_npc, in_excp_valid, in_excp_ecode, out_ready,
    input  in_ready, out_valid, out_vaddr, out_instr, out_npc, out_excp
  );

  modport slave (
    input  in_valid, in_vaddr, in_instr, in_npc, in_excp_valid, in_excp_ecode, out_ready,
    output in_ready, out_valid, out_vaddr, out_instr, out_npc, out_excp
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction queue between ICache fetch and decode; entries visible one cycle after write.
// in_ready needs room for a full fetch group (no same-cycle dequeue credit); flush/reset empty it.
module fetch_buffer #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 16,
  parameter int VALEN        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  fetch_buffer_if.slave fb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [VALEN-1:0] vaddr;
    logic [31:0]      instr;
    logic [VALEN-1:0] npc;
    logic             excp_v;
    logic [5:0]       ecode;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [CW-1:0] n_enq, n_deq;
  logic          accept_rdy;
  logic [FETCH_WIDTH-1:0]         wr_en;
  logic [FETCH_WIDTH-1:0][PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  entry_t        rd_entry;
  logic          blocked;

  assign accept_rdy  = !flush_i && ((CW'(DEPTH) - count) >= CW'(FETCH_WIDTH));
  assign fb.in_ready = accept_rdy;

  // An exception keeps only the lowest valid lane; survivors are packed from tail upward.
  always_comb begin
    wr_en = fb.in_valid;
    if (fb.in_excp_valid) wr_en = fb.in_valid & (~fb.in_valid + FETCH_WIDTH'(1));
    if (!accept_rdy) wr_en = '0;
    n_enq  = '0;
    wr_idx = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = tail + n_enq[PW-1:0];
      if (wr_en[i]) n_enq = n_enq + CW'(1);
    end
  end

  // An exception entry is only ever presented in lane 0, and nothing follows it that cycle.
  always_comb begin
    fb.out_valid = '0;
    fb.out_vaddr = '0;
    fb.out_instr = '0;
    fb.out_npc   = '0;
    fb.out_excp  = '0;
    rd_idx       = '0;
    rd_entry     = '0;
    blocked      = 1'b0;
    n_deq        = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      rd_idx   = head + PW'(i);
      rd_entry = mem[rd_idx];
      fb.out_valid[i] = (count > CW'(i)) && !blocked && ((i == 0) || !rd_entry.excp_v);
      fb.out_vaddr[i] = rd_entry.vaddr;
      fb.out_instr[i] = rd_entry.instr;
      fb.out_npc[i]   = rd_entry.npc;
      fb.out_excp[i]  = {rd_entry.excp_v, rd_entry.ecode};
      blocked = blocked | rd_entry.excp_v;
      if (fb.out_valid[i]) n_deq = n_deq + CW'(1);
    end
    if (!fb.out_ready) n_deq = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + n_enq[PW-1:0];
      head  <= head + n_deq[PW-1:0];
      count <= count + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (rst_n && wr_en[i]) begin
        mem[wr_idx[i]] <= '{vaddr:  fb.in_vaddr[i],
                            instr:  fb.in_instr[i],
                            npc:    fb.in_npc[i],
                            excp_v: fb.in_excp_valid,
                            ecode:  fb.in_excp_ecode};
      end
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: one task per scenario, inline expected-value checks.
module tb_fetch_buffer;
  logic clk;
  logic rst_n;
  logic flush_i;
  int   n_cmp;
  int   n_err;

  fetch_buffer_if #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .VALEN(32)) bus ();

  fetch_buffer #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(16), .VALEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .fb      (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid      = 2'b00;
    bus.in_vaddr      = '0;
    bus.in_instr      = '0;
    bus.in_npc        = '0;
    bus.in_excp_valid = 1'b0;
    bus.in_excp_ecode = 6'd0;
  endtask

  task automatic push_group(input logic [31:0] base, input logic [1:0] mask);
    bus.in_valid      = mask;
    bus.in_excp_valid = 1'b0;
    bus.in_excp_ecode = 6'd0;
    for (int l = 0; l < 2; l++) begin
      bus.in_vaddr[l] = base + 32'(4 * l);
      bus.in_instr[l] = ~(base + 32'(4 * l));
      bus.in_npc[l]   = base + 32'(4 * l) + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; bus.out_ready = 1'b0; idle();
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL reset_out_valid got=%b exp=00", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL empty_out_ready got=%b exp=00", bus.out_valid); end
    step();
  endtask

  task automatic test_stream();
    logic [31:0] exp0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) push_group(32'h1000 + 32'(8 * k), 2'b11); else idle();
      @(negedge clk);
      exp0 = 32'h1000 + 32'(8 * (k - 1));
      if (k == 0 || k == 9) begin
        n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL stream_empty k=%0d got=%b exp=00", k, bus.out_valid); end
      end else begin
        n_cmp++; if (bus.out_valid !== 2'b11) begin n_err++; $display("FAIL stream_valid k=%0d got=%b exp=11", k, bus.out_valid); end
        n_cmp++; if (bus.out_vaddr[0] !== exp0) begin n_err++; $display("FAIL stream_vaddr0 k=%0d got=%h exp=%h", k, bus.out_vaddr[0], exp0); end
        n_cmp++; if (bus.out_vaddr[1] !== exp0 + 32'd4) begin n_err++; $display("FAIL stream_vaddr1 k=%0d got=%h exp=%h", k, bus.out_vaddr[1], exp0 + 32'd4); end
        n_cmp++; if (bus.out_instr[1] !== ~(exp0 + 32'd4)) begin n_err++; $display("FAIL stream_instr1 k=%0d got=%h exp=%h", k, bus.out_instr[1], ~(exp0 + 32'd4)); end
        n_cmp++; if (bus.out_npc[0] !== exp0 + 32'd4) begin n_err++; $display("FAIL stream_npc0 k=%0d got=%h exp=%h", k, bus.out_npc[0], exp0 + 32'd4); end
      end
      step();
    end
  endtask

  task automatic test_full();
    int   got;
    logic acc;
    bus.out_ready = 1'b0;
    for (int g = 0; g < 9; g++) begin
      push_group(32'h3000 + 32'(8 * g), 2'b11);
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== (g < 8)) begin n_err++; $display("FAIL full_in_ready g=%0d got=%b exp=%b", g, bus.in_ready, g < 8); end
      if (g < 8) step();
    end
    step();
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_held_in_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.out_vaddr[0] !== 32'h3000) begin n_err++; $display("FAIL full_head got=%h exp=3000", bus.out_vaddr[0]); end
    step();
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 18; c++) begin
      @(negedge clk);
      acc = (bus.in_valid != 2'b00) && bus.in_ready;
      n_cmp++; if (bus.out_valid !== 2'b11) begin n_err++; $display("FAIL full_drain_valid c=%0d got=%b exp=11", c, bus.out_valid); end
      for (int l = 0; l < 2; l++) begin
        if (bus.out_valid[l]) begin
          n_cmp++; if (bus.out_vaddr[l] !== 32'h3000 + 32'(4 * got)) begin n_err++; $display("FAIL full_drain_order got=%h exp=%h", bus.out_vaddr[l], 32'h3000 + 32'(4 * got)); end
          got++;
        end
      end
      step();
      if (acc) idle();
    end
    n_cmp++; if (got !== 18) begin n_err++; $display("FAIL full_drain_total got=%0d exp=18", got); end
  endtask

  task automatic test_wrap();
    int          got;
    int          ng;
    logic [31:0] base;
    bus.out_ready = 1'b0; idle();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      base = (ph == 0) ? 32'h4000 : 32'h5000;
      ng   = (ph == 0) ? 7 : 3;
      for (int g = 0; g < ng; g++) begin
        push_group(base + 32'(8 * g), 2'b11);
        step();
      end
      idle();
      bus.out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 2 * ng; c++) begin
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 2'b11) begin n_err++; $display("FAIL wrap_valid ph=%0d c=%0d got=%b exp=11", ph, c, bus.out_valid); end
        for (int l = 0; l < 2; l++) begin
          if (bus.out_valid[l]) begin
            n_cmp++; if (bus.out_vaddr[l] !== base + 32'(4 * got)) begin n_err++; $display("FAIL wrap_order ph=%0d got=%h exp=%h", ph, bus.out_vaddr[l], base + 32'(4 * got)); end
            got++;
          end
        end
        step();
      end
      n_cmp++; if (got !== 2 * ng) begin n_err++; $display("FAIL wrap_total ph=%0d got=%0d exp=%0d", ph, got, 2 * ng); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL wrap_empty ph=%0d got=%b exp=00", ph, bus.out_valid); end
      bus.out_ready = 1'b0;
      step();
    end
  endtask

  task automatic test_mask();
    bus.out_ready = 1'b0;
    push_group(32'h2000, 2'b10);
    bus.in_vaddr[0] = 32'hDEAD0000;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL mask_write_cycle got=%b exp=00", bus.out_valid); end
    step(); idle();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b01) begin n_err++; $display("FAIL mask_valid got=%b exp=01", bus.out_valid); end
    n_cmp++; if (bus.out_vaddr[0] !== 32'h2004) begin n_err++; $display("FAIL mask_vaddr got=%h exp=2004", bus.out_vaddr[0]); end
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL mask_drained got=%b exp=00", bus.out_valid); end
    step();
  endtask

  task automatic test_exception();
    bus.out_ready = 1'b1;
    push_group(32'h6000, 2'b01);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL excp_c0_valid got=%b exp=00", bus.out_valid); end
    step();
    push_group(32'h6100, 2'b11);
    bus.in_excp_valid = 1'b1;
    bus.in_excp_ecode = 6'h08;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b01) begin n_err++; $display("FAIL excp_a_valid got=%b exp=01", bus.out_valid); end
    n_cmp++; if (bus.out_vaddr[0] !== 32'h6000) begin n_err++; $display("FAIL excp_a_vaddr got=%h exp=6000", bus.out_vaddr[0]); end
    n_cmp++; if (bus.out_excp[0][6] !== 1'b0) begin n_err++; $display("FAIL excp_a_flag got=%b exp=0", bus.out_excp[0][6]); end
    step(); idle();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b01) begin n_err++; $display("FAIL excp_e_valid got=%b exp=01", bus.out_valid); end
    n_cmp++; if (bus.out_vaddr[0] !== 32'h6100) begin n_err++; $display("FAIL excp_e_vaddr got=%h exp=6100", bus.out_vaddr[0]); end
    n_cmp++; if (bus.out_excp[0] !== 7'h48) begin n_err++; $display("FAIL excp_e_code got=%h exp=48", bus.out_excp[0]); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL excp_lane1_dropped got=%b exp=00", bus.out_valid); end
    step();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      push_group(32'h7000 + 32'(8 * g), 2'b11);
      step();
    end
    push_group(32'h7100, 2'b11);
    bus.out_ready = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_cycle_in_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 2'b11) begin n_err++; $display("FAIL flush_cycle_valid got=%b exp=11", bus.out_valid); end
    step();
    flush_i = 1'b0; idle(); bus.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL flush_after_valid got=%b exp=00", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_after_in_ready got=%b exp=1", bus.in_ready); end
    step();
    push_group(32'h7200, 2'b11);
    step(); idle();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 2'b11) begin n_err++; $display("FAIL flush_refill_valid got=%b exp=11", bus.out_valid); end
    n_cmp++; if (bus.out_vaddr[0] !== 32'h7200) begin n_err++; $display("FAIL flush_refill_vaddr0 got=%h exp=7200", bus.out_vaddr[0]); end
    n_cmp++; if (bus.out_vaddr[1] !== 32'h7204) begin n_err++; $display("FAIL flush_refill_vaddr1 got=%h exp=7204", bus.out_vaddr[1]); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_full();
    test_wrap();
    test_mask();
    test_exception();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
